// File: rtl/encrypt_round_ctrl_if.sv
// Byte-in / ciphertext-out handshake bundle for encrypt_round_ctrl.
// The master side is the byte source plus the ciphertext sink. The slave side is the round controller.
interface encrypt_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic [7:0] key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] enc_number;

  modport master (
    output in_valid, number, key, out_ready,
    input  in_ready, out_valid, enc_number
  );

  modport slave (
    input  in_valid, number, key, out_ready,
    output in_ready, out_valid, enc_number
  );
endinterface

// File: rtl/encrypt_round_ctrl.sv
// Multi-round nibble-encryption sequencer: accepts a plaintext/key byte pair and runs ROUNDS rounds
// on one shared round datapath, rotating the key each round, then presents the ciphertext.
module encrypt_round_ctrl #(
  parameter int ROUNDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  encrypt_round_ctrl_if.slave  bus,
  output logic                 o_busy,
  output logic [3:0]           o_round_idx,
  output logic [1:0]           o_fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  fsm_t       r_fsm, w_fsm_nxt;
  logic [7:0] r_state, w_state_nxt;
  logic [7:0] r_key, w_key_nxt;
  logic [3:0] r_round_idx, w_round_idx_nxt;

  logic [2:0] w_rot;
  logic [7:0] w_round_key;
  logic [3:0] w_lo, w_hi, w_t;
  logic [7:0] w_exp, w_x, w_round_out;

  // Round datapath. An 8-bit rotate by round_idx wraps modulo 8.
  assign w_rot       = r_round_idx[2:0];
  assign w_round_key = (r_key << w_rot) | (r_key >> (4'd8 - {1'b0, w_rot}));
  assign w_lo        = r_state[3:0];
  assign w_hi        = r_state[7:4];
  assign w_exp       = {w_lo[3], w_lo[0], w_lo[1], w_lo[2], w_lo[1], w_lo[3], w_lo[2], w_lo[0]};
  assign w_x         = w_round_key ^ w_exp;
  assign w_t         = w_x[7:4] + w_x[3:0] + {3'b000, w_round_key[0]};
  assign w_round_out = {w_lo, w_hi ^ w_t};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm       <= ST_IDLE;
      r_state     <= 8'h00;
      r_key       <= 8'h00;
      r_round_idx <= 4'd0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_round_idx <= w_round_idx_nxt;
    end
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high. valid never
  // depends on ready. Once out_valid is high, it and enc_number hold until the transfer edge.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_round_idx_nxt = r_round_idx;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt     = bus.number;
          w_key_nxt       = bus.key;
          w_round_idx_nxt = 4'd0;
          w_fsm_nxt       = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = w_round_out;
        if (r_round_idx == LAST_ROUND) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_round_idx_nxt = r_round_idx + 4'd1;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_fsm_nxt       = ST_IDLE;
          w_round_idx_nxt = 4'd0;
        end
      end
      default: begin
        w_fsm_nxt       = ST_IDLE;
        w_round_idx_nxt = 4'd0;
      end
    endcase
  end

  assign bus.enc_number = r_state;
  assign o_busy         = (r_fsm != ST_IDLE);
  assign o_round_idx    = r_round_idx;
  assign o_fsm_state    = r_fsm;

endmodule
